// File: rtl/patbuf_pkg.sv
// Shared definitions for the pattern-buffer configuration path: widths, the loader
// state encoding and the queued command record.
package patbuf_pkg;
  localparam int ADDR_W = 3;
  localparam int BYTE_W = 8;
  localparam int BIT_W  = $clog2(BYTE_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2,
    GAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BYTE_W-1:0] data;
    logic              last;
  } cmd_t;
endpackage

// File: rtl/patload_fifo.sv
// Command FIFO for the pattern loader. Push is ignored when full and pop is ignored
// when empty, so neither overflow nor underflow can happen.
module patload_fifo
  import patbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  cmd_t                     i_wdata,
  input  logic                     i_pop,
  output cmd_t                     o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PTR_W = $clog2(DEPTH);

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/pattern_loader.sv
// Serialises host bytes MSB-first onto sin with ssel/saddr framing and collects the
// bits returned on sout into read-back bytes.
module pattern_loader
  import patbuf_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [BYTE_W-1:0] cmd_data,
  input  logic              cmd_last,
  output logic              sin,
  output logic              ssel,
  output logic [ADDR_W-1:0] saddr,
  input  logic              sout,
  output logic              rb_valid,
  output logic [BYTE_W-1:0] rb_data,
  output logic              busy,
  output state_t            dbg_state
);
  localparam int GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // Host port: a byte transfers on every rising edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on registered state, never on cmd_valid.
  cmd_t                      w_wdata;
  cmd_t                      w_rdata;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic                      w_bit_done;

  state_t                    r_state;
  logic                      r_ready_en;
  logic [BYTE_W-2:0]         r_shreg;
  logic [BIT_W-1:0]          r_bitcnt;
  logic                      r_last;
  logic [GCNT_W-1:0]         r_gcnt;
  logic                      r_sin;
  logic                      r_ssel;
  logic [ADDR_W-1:0]         r_saddr;
  logic [BYTE_W-2:0]         r_rbreg;
  logic [BIT_W-1:0]          r_rbcnt;
  logic                      r_rb_valid;
  logic [BYTE_W-1:0]         r_rb_data;

  assign w_wdata    = '{addr: cmd_addr, data: cmd_data, last: cmd_last};
  assign w_push     = cmd_valid && cmd_ready;
  assign w_bit_done = (r_bitcnt == BIT_W'(BYTE_W-1));

  patload_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (sclk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      IDLE, STALL: w_pop = !w_empty;
      SHIFT:       w_pop = w_bit_done && !r_last && !w_empty;
      default:     w_pop = 1'b0;
    endcase
  end

  // Every pop loads the shifter, so the load path is shared by IDLE, STALL and SHIFT.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ready_en <= 1'b0;
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      r_last     <= 1'b0;
      r_gcnt     <= '0;
      r_sin      <= 1'b0;
      r_ssel     <= 1'b0;
      r_saddr    <= '0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_pop) begin
        r_shreg  <= w_rdata.data[BYTE_W-2:0];
        r_sin    <= w_rdata.data[BYTE_W-1];
        r_ssel   <= 1'b1;
        r_bitcnt <= '0;
        r_last   <= w_rdata.last;
        r_state  <= SHIFT;
        if (r_state == IDLE) r_saddr <= w_rdata.addr;
      end else begin
        case (r_state)
          SHIFT: begin
            if (w_bit_done) begin
              r_ssel  <= 1'b0;
              r_sin   <= 1'b0;
              r_gcnt  <= '0;
              r_state <= r_last ? GAP : STALL;
            end else begin
              r_sin    <= r_shreg[BYTE_W-2];
              r_shreg  <= {r_shreg[BYTE_W-3:0], 1'b0};
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
          GAP: begin
            if (r_gcnt == GCNT_W'(GAP_CYCLES-1)) r_state <= IDLE;
            else                                 r_gcnt  <= r_gcnt + 1'b1;
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  // The buffers present their next bit on sout and shift on the same edges as sin.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rbreg    <= '0;
      r_rbcnt    <= '0;
      r_rb_valid <= 1'b0;
      r_rb_data  <= '0;
    end else begin
      r_rb_valid <= 1'b0;
      if (r_ssel) begin
        r_rbreg <= {r_rbreg[BYTE_W-3:0], sout};
        r_rbcnt <= r_rbcnt + 1'b1;
        if (r_rbcnt == BIT_W'(BYTE_W-1)) begin
          r_rb_valid <= 1'b1;
          r_rb_data  <= {r_rbreg, sout};
        end
      end
    end
  end

  assign cmd_ready = r_ready_en && !w_full;
  assign sin       = r_sin;
  assign ssel      = r_ssel;
  assign saddr     = r_saddr;
  assign rb_valid  = r_rb_valid;
  assign rb_data   = r_rb_data;
  assign busy      = (r_state != IDLE) || (w_count != '0);
  assign dbg_state = r_state;
endmodule

// File: tb/tb_pattern_loader.sv
// Bench for pattern_loader: table of single-byte frames plus directed multi-cycle
// sequences (multi-byte frame, FIFO full, stall, reset mid-byte).
module tb_pattern_loader;
  import patbuf_pkg::*;

  logic        sclk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_addr;
  logic [7:0]  cmd_data;
  logic        cmd_last;
  logic        sin;
  logic        ssel;
  logic [2:0]  saddr;
  logic        sout;
  logic        rb_valid;
  logic [7:0]  rb_data;
  logic        busy;
  state_t      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  pattern_loader #(.FIFO_DEPTH(4), .GAP_CYCLES(2)) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_last  (cmd_last),
    .sin       (sin),
    .ssel      (ssel),
    .saddr     (saddr),
    .sout      (sout),
    .rb_valid  (rb_valid),
    .rb_data   (rb_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // 8-bit buffer model on the far end of the serial link
  logic       buf_load;
  logic [7:0] buf_q;
  always @(posedge sclk) begin
    if (buf_load)  buf_q <= 8'hC3;
    else if (ssel) buf_q <= {buf_q[6:0], sin};
  end
  assign sout = buf_q[7];

  // monitor: rebuilds bytes from sin, measures ssel runs, collects read-back bytes
  logic [10:0] got_q[$];
  int          run_q[$];
  logic [7:0]  rb_q[$];
  logic [7:0]  mon_sh;
  logic [2:0]  mon_addr;
  int          mon_nb = 0;
  int          mon_run = 0;
  int          addr_bad = 0;
  always @(negedge sclk) begin
    if (!rst_n) begin
      mon_nb  = 0;
      mon_run = 0;
    end else begin
      if (rb_valid) rb_q.push_back(rb_data);
      if (ssel) begin
        if (mon_nb == 0) mon_addr = saddr;
        else if (saddr !== mon_addr) addr_bad++;
        mon_sh = {mon_sh[6:0], sin};
        mon_nb++;
        mon_run++;
        if (mon_nb == 8) begin
          got_q.push_back({mon_addr, mon_sh});
          mon_nb = 0;
        end
      end else if (mon_run != 0) begin
        run_q.push_back(mon_run);
        mon_run = 0;
      end
    end
  end

  // scoreboard
  logic [10:0] exp_q[$];
  int got_rd = 0;
  int run_rd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_stream(input string name);
    check({name, "_count"}, got_q.size() - got_rd, exp_q.size());
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      check({name, "_byte"}, {21'd0, got_q[got_rd]}, {21'd0, exp_q.pop_front()});
      got_rd++;
    end
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  task automatic check_run(input string name, input int exp);
    if (run_rd < run_q.size()) begin
      check(name, run_q[run_rd], exp);
      run_rd++;
    end else begin
      check(name, 32'hFFFF_FFFF, exp);
    end
  endtask

  // driver tasks: called and return at a falling edge
  task automatic push(input logic [2:0] a, input logic [7:0] d, input logic l, output int stalls);
    stalls    = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_last  = l;
    while (!cmd_ready && stalls < 100) begin
      @(negedge sclk);
      stalls++;
    end
    if (!cmd_ready) check("push_timeout", 0, 1);
    @(posedge sclk);
    @(negedge sclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int gap);
    int  t;
    bit  seen;
    t = 0; gap = 0; seen = 0;
    while ((!seen || busy) && t < 400) begin
      if (ssel) begin
        seen = 1;
        gap  = 0;
      end else if (seen) begin
        gap++;
      end
      @(negedge sclk);
      t++;
    end
    if (t >= 400) check("idle_timeout", 0, 1);
  endtask

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic       preload;
    logic [7:0] exp_rb;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int st, lat, gap, rb_before;
    vecs[0] = '{addr: 3'd3, data: 8'hA5, preload: 1'b1, exp_rb: 8'hC3};
    vecs[1] = '{addr: 3'd5, data: 8'h00, preload: 1'b1, exp_rb: 8'hC3};
    vecs[2] = '{addr: 3'd7, data: 8'hFF, preload: 1'b0, exp_rb: 8'h00};
    vecs[3] = '{addr: 3'd0, data: 8'h5A, preload: 1'b0, exp_rb: 8'hFF};
    vecs[4] = '{addr: 3'd6, data: 8'h81, preload: 1'b0, exp_rb: 8'h5A};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_last = 1'b0;
    buf_load = 1'b0;

    repeat (2) @(negedge sclk);
    check("rst_ssel", ssel, 0);
    check("rst_sin", sin, 0);
    check("rst_saddr", saddr, 0);
    check("rst_rb_valid", rb_valid, 0);
    check("rst_rb_data", rb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    @(negedge sclk);
    check("ready_after_rst", cmd_ready, 1);

    // single-byte frames
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].preload) begin
        buf_load = 1'b1;
        @(negedge sclk);
        buf_load = 1'b0;
      end
      rb_before = rb_q.size();
      push(vecs[i].addr, vecs[i].data, 1'b1, st);
      check("v_busy_after_push", busy, 1);
      lat = 0;
      while (!ssel && lat < 20) begin
        @(negedge sclk);
        lat++;
      end
      check("v_latency", lat, 1);
      check("v_saddr", saddr, vecs[i].addr);
      wait_idle(gap);
      check("v_gap", gap, 2);
      check_run("v_run", 8);
      exp_q.push_back({vecs[i].addr, vecs[i].data});
      check_stream("v");
      check("v_rb_count", rb_q.size() - rb_before, 1);
      if (rb_q.size() > rb_before) check("v_rb_data", rb_q[rb_before], vecs[i].exp_rb);
    end

    // three-byte frame, later addresses ignored
    push(3'd4, 8'h12, 1'b0, st);
    push(3'd1, 8'h34, 1'b0, st);
    push(3'd1, 8'h56, 1'b1, st);
    wait_idle(gap);
    check("f3_gap", gap, 2);
    check_run("f3_run", 24);
    exp_q.push_back({3'd4, 8'h12});
    exp_q.push_back({3'd4, 8'h34});
    exp_q.push_back({3'd4, 8'h56});
    check_stream("f3");

    // fill the FIFO while the first byte shifts
    push(3'd1, 8'h11, 1'b0, st);
    push(3'd7, 8'h22, 1'b0, st);
    push(3'd7, 8'h33, 1'b0, st);
    push(3'd7, 8'h44, 1'b0, st);
    push(3'd7, 8'h55, 1'b1, st);
    check("full_ready", cmd_ready, 0);
    push(3'd4, 8'h66, 1'b1, st);
    check("full_hold_cycles", st, 5);
    wait_idle(gap);
    check("full_gap", gap, 2);
    check_run("full_run_a", 40);
    check_run("full_run_b", 8);
    exp_q.push_back({3'd1, 8'h11});
    exp_q.push_back({3'd1, 8'h22});
    exp_q.push_back({3'd1, 8'h33});
    exp_q.push_back({3'd1, 8'h44});
    exp_q.push_back({3'd1, 8'h55});
    exp_q.push_back({3'd4, 8'h66});
    check_stream("full");

    // stall between bytes of one frame
    push(3'd5, 8'h80, 1'b0, st);
    lat = 0;
    while (!ssel && lat < 20) begin @(negedge sclk); lat++; end
    while (ssel && lat < 40) begin @(negedge sclk); lat++; end
    for (int k = 0; k < 6; k++) begin
      check("stall_ssel", ssel, 0);
      check("stall_saddr", saddr, 5);
      check("stall_state", dbg_state, STALL);
      @(negedge sclk);
    end
    push(3'd2, 8'h01, 1'b1, st);
    wait_idle(gap);
    check("stall_gap", gap, 2);
    check_run("stall_run_a", 8);
    check_run("stall_run_b", 8);
    exp_q.push_back({3'd5, 8'h80});
    exp_q.push_back({3'd5, 8'h01});
    check_stream("stall");

    // reset in the middle of a byte with more bytes queued
    push(3'd6, 8'hF0, 1'b0, st);
    push(3'd1, 8'h0F, 1'b0, st);
    push(3'd1, 8'hAA, 1'b1, st);
    repeat (3) @(negedge sclk);
    check("mid_ssel_before", ssel, 1);
    check("mid_state_before", dbg_state, SHIFT);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ssel", ssel, 0);
    check("mid_rst_sin", sin, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_saddr", saddr, 0);
    @(negedge sclk);
    @(negedge sclk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge sclk);
      check("mid_after_ssel", ssel, 0);
      check("mid_after_busy", busy, 0);
    end
    check_stream("mid_discard");

    // recovery frame
    push(3'd2, 8'h3C, 1'b1, st);
    wait_idle(gap);
    check_run("rec_run", 8);
    exp_q.push_back({3'd2, 8'h3C});
    check_stream("rec");
    check("saddr_stable", addr_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end
endmodule
